alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execution-side consumer of the 3-bit ALU control code produced by the ALU control decoder.
//  Executes one operation per accepted request: single-cycle logic/arith/shift/compare ops,
//  and an iterative shift-add multiplier for MUL (RV32M funct7=01, funct3=000).
//  Sits between decode and writeback; valid/ready on input, one-cycle done pulse on output.
// PARAMETERS
//  WIDTH   32   operand/result width in bits (>=4, power of two)
// PORTS
//  clk        in   1      single system clock, all state updates on rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      request present on alu_ctrl/src_a/src_b
//  in_ready   out  1      unit can accept (comb: state==IDLE)
//  alu_ctrl   in   3      ALU control code (table below)
//  src_a      in   WIDTH  operand A
//  src_b      in   WIDTH  operand B
//  busy       out  1      multiply in progress (state==MUL)
//  out_valid  out  1      one-cycle pulse: result/zero valid
//  result     out  WIDTH  registered result, held until next completion
//  zero       out  1      registered (result==0), updated with result
// BEHAVIOUR
//  Codes: 010 ADD a+b | 110 SUB a-b | 000 AND | 001 OR | 111 SLL a<<b[log2W-1:0]
//    011 SRL logical a>>b[log2W-1:0] | 100 SLT signed(a<b)?1:0 | 101 MUL low WIDTH bits of a*b.
//  ADD/SUB/MUL wrap modulo 2^WIDTH; no overflow flag.
//  Reset (sync, rst=1 at edge): state=IDLE, out_valid=0, result=0, zero=1, busy=0; any
//    in-flight multiply is discarded, no out_valid for it ever appears.
//  Accept: edge where in_valid&&in_ready. Operands/code sampled only at accept edge;
//    later src/ctrl changes do not affect an in-flight op. in_valid with in_ready=0 ignored
//    (not queued); requester must hold it.
//  FSM IDLE/MUL:
//    IDLE, accept non-MUL: result/zero loaded at accept edge, out_valid=1 next cycle, stay IDLE.
//      Latency 1; back-to-back accepts every cycle allowed.
//    IDLE, accept MUL: load mcand=src_a, mplier=src_b, acc=0, count=WIDTH; -> MUL. out_valid=0.
//    MUL, every edge: if mplier[0] acc+=mcand; mcand<<=1; mplier>>=1; count-=1.
//      Finish when count==1 before the edge: result=acc_next, zero updated, out_valid=1 next
//      cycle, -> IDLE. Latency exactly WIDTH cycles.
//  out_valid is 1 for exactly one cycle per accepted op, never otherwise; in_ready is high
//    during that cycle so a new op may be accepted in the same cycle.
//  Idle with no accept: out_valid=0, result/zero hold.
// CONFIGURATION
//  EARLY_TERM_EN defined: in MUL, also finish on an edge where mplier>>1 == 0 (remaining
//    multiplier bits zero); result identical. Latency = 1 + index of MSB set in src_b
//    (src_b=0 or 1 -> 1 cycle).
//  Undefined: MUL latency always WIDTH regardless of operands.
// TESTING
//  ADD 5+7 -> out_valid 1 cycle after accept, result=12, zero=0; SUB 9-9 -> result=0, zero=1.
//  SLT a=0xFFFFFFFF b=1 -> 1; SRL 0x80000000 by 31 -> 1; SLL 1 by 33 (amt 1) -> 2.
//  MUL 6*7 (W=32): busy=1, in_ready=0 for 32 cycles; ADD on in_valid meanwhile ignored;
//    out_valid at cycle 32, result=42; the ADD then accepted, completes 1 cycle later.
//  MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE; MUL 0x10000*0x10000 -> 0, zero=1.
//  rst=1 at cycle 10 of MUL -> next cycle IDLE, result=0, zero=1, out_valid never pulses for it.
//  EARLY_TERM_EN: MUL 6*3 -> out_valid after 2 cycles, result=18; MUL 5*0 -> 1 cycle, result=0.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: request/response bundle between decode and the ALU execution unit.
interface alu_exec_unit_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    modport master (output in_valid, alu_ctrl, src_a, src_b,
                    input  in_ready, busy, out_valid, result, zero);
    modport slave  (input  in_valid, alu_ctrl, src_a, src_b,
                    output in_ready, busy, out_valid, result, zero);
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-cycle ALU ops plus an iterative shift-add MUL.
// Optional EARLY_TERM_EN ends a multiply once the remaining multiplier bits are zero.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    alu_exec_unit_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_mcand, r_mplier, r_acc, r_result;
    logic [WIDTH-1:0] w_alu, w_acc_nxt;
    logic [CW-1:0]    r_count;
    logic             r_zero, r_out_valid;
    logic             w_accept, w_mul_done;
    logic [SW-1:0]    w_shamt;

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.busy      = (r_state == MUL);
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;

    assign w_accept  = bus.in_valid && bus.in_ready;
    assign w_shamt   = bus.src_b[SW-1:0];
    assign w_acc_nxt = r_mplier[0] ? r_acc + r_mcand : r_acc;
`ifdef EARLY_TERM_EN
    assign w_mul_done = (r_count == CW'(1)) || (r_mplier[WIDTH-1:1] == '0);
`else
    assign w_mul_done = (r_count == CW'(1));
`endif

    always_comb begin
        w_alu = '0;
        case (bus.alu_ctrl)
            3'b010:  w_alu = bus.src_a + bus.src_b;
            3'b110:  w_alu = bus.src_a - bus.src_b;
            3'b000:  w_alu = bus.src_a & bus.src_b;
            3'b001:  w_alu = bus.src_a | bus.src_b;
            3'b111:  w_alu = bus.src_a << w_shamt;
            3'b011:  w_alu = bus.src_a >> w_shamt;
            3'b100:  w_alu = {{(WIDTH-1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)};
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IDLE && w_accept && bus.alu_ctrl == OP_MUL)
            w_state_nxt = MUL;
        else if (r_state == MUL && w_mul_done)
            w_state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= 1'b0;
            if (w_accept) begin
                if (bus.alu_ctrl == OP_MUL) begin
                    r_mcand  <= bus.src_a;
                    r_mplier <= bus.src_b;
                    r_acc    <= '0;
                    r_count  <= CW'(WIDTH);
                end else begin
                    r_result    <= w_alu;
                    r_zero      <= (w_alu == '0);
                    r_out_valid <= 1'b1;
                end
            end
            if (r_state == MUL) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count - CW'(1);
                if (w_mul_done) begin
                    r_result    <= w_acc_nxt;
                    r_zero      <= (w_acc_nxt == '0);
                    r_out_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors checked by a cycle-level reference model plus literal expectations.
module tb_alu_exec_unit;
    localparam int W = 32;
`ifdef EARLY_TERM_EN
    localparam int L_B7 = 3, L_B2 = 2, L_B10K = 17, L_B3 = 2, L_B0 = 1;
`else
    localparam int L_B7 = W, L_B2 = W, L_B10K = W, L_B3 = W, L_B0 = W;
`endif

    typedef struct { int due; logic [W-1:0] res; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int cmp = 0;
    int err = 0;
    int cyc = 0;
    int busy_until = -1;
    int acc_cnt = 0;
    bit started = 0;
    logic [W-1:0] cur_res = '0;
    exp_t q[$];

    alu_exec_unit_if #(.WIDTH(W)) bus ();
    alu_exec_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_op(logic [2:0] c, logic [W-1:0] a, logic [W-1:0] b);
        logic [W-1:0] r;
        case (c)
            3'b010:  r = a + b;
            3'b110:  r = a - b;
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b111:  r = a << b[4:0];
            3'b011:  r = a >> b[4:0];
            3'b100:  r = ($signed(a) < $signed(b)) ? 1 : 0;
            default: r = a * b;
        endcase
        return r;
    endfunction

    function automatic int mul_lat(logic [W-1:0] b);
        int l;
`ifdef EARLY_TERM_EN
        l = 1;
        for (int i = 0; i < W; i++) if (b[i]) l = i + 1;
`else
        l = W;
`endif
        return l;
    endfunction

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] req);
        cmp++;
        if (act !== req) begin
            err++;
            $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, req);
        end
    endtask

    // Reference model: tracks acceptance and when each result must appear.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            busy_until = cyc;
            cur_res = '0;
            started = 1;
        end else if (bus.in_valid && cyc > busy_until) begin
            int l;
            l = (bus.alu_ctrl == 3'b101) ? mul_lat(bus.src_b) : 0;
            q.push_back('{due: cyc + l, res: ref_op(bus.alu_ctrl, bus.src_a, bus.src_b)});
            if (l > 0) busy_until = cyc + l;
            acc_cnt++;
        end
    end

    initial forever begin
        logic ov;
        @(negedge clk);
        if (started) begin
            ov = (q.size() > 0 && q[0].due == cyc);
            if (ov) cur_res = q.pop_front().res;
            check("out_valid", W'(bus.out_valid), W'(ov));
            check("in_ready", W'(bus.in_ready), W'(cyc >= busy_until));
            check("busy", W'(bus.busy), W'(cyc < busy_until));
            check("result", bus.result, cur_res);
            check("zero", W'(bus.zero), W'(cur_res == '0));
        end
    end

    task automatic issue(logic [2:0] c, logic [W-1:0] a, logic [W-1:0] b);
        int n0, t;
        n0 = acc_cnt;
        bus.in_valid = 1'b1;
        bus.alu_ctrl = c;
        bus.src_a = a;
        bus.src_b = b;
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (acc_cnt == n0 && t < 200);
        if (acc_cnt == n0) check("accept_timeout", 0, 1);
        bus.src_a = ~a;
        bus.src_b = b ^ 32'h5A5A_0F0F;
    endtask

    task automatic idle(int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lit(string name, logic [2:0] c, logic [W-1:0] a, logic [W-1:0] b,
                       logic [W-1:0] r, int l);
        int n;
        issue(c, a, b);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_res"}, bus.result, r);
        check({name, "_zero"}, W'(bus.zero), W'(r == '0));
        check({name, "_lat"}, W'(n), W'(l));
        idle(1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.alu_ctrl = 3'b000;
        bus.src_a = '0;
        bus.src_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", bus.result, '0);
        check("rst_zero", W'(bus.zero), 1);
        check("rst_ready", W'(bus.in_ready), 1);
        rst = 1'b0;
        idle(1);
        lit("add", 3'b010, 5, 7, 12, 0);
        lit("sub", 3'b110, 9, 9, 0, 0);
        lit("slt", 3'b100, 32'hFFFF_FFFF, 1, 1, 0);
        lit("srl", 3'b011, 32'h8000_0000, 31, 1, 0);
        lit("sll", 3'b111, 1, 33, 2, 0);
        lit("mul67", 3'b101, 6, 7, 42, L_B7);
        lit("mulff", 3'b101, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, L_B2);
        lit("mul10k", 3'b101, 32'h0001_0000, 32'h0001_0000, 0, L_B10K);
        lit("mul63", 3'b101, 6, 3, 18, L_B3);
        lit("mul50", 3'b101, 5, 0, 0, L_B0);
        issue(3'b001, 32'hF0F0_0000, 32'h0000_0F0F);
        issue(3'b000, 32'hFF00_FF00, 32'h0FF0_0FF0);
        issue(3'b010, 32'hFFFF_FFFF, 1);
        issue(3'b100, 3, 32'h8000_0000);
        issue(3'b101, 6, 7);
        issue(3'b010, 1, 2);
        issue(3'b101, 32'h1234_5678, 32'h8765_4321);
        issue(3'b110, 0, 1);
        idle(3);
        issue(3'b101, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        idle(9);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_result", bus.result, '0);
        check("midrst_ready", W'(bus.in_ready), 1);
        idle(40);
        issue(3'b011, 32'hFFFF_FFFF, 4);
        idle(3);
        check("drained", W'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout @cyc %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
